speed_tracker: RTL and testbench
================================

# speed_tracker

Parametrised successor to the single-car speed stage. It sits between the detection byte stream and the speed/location memories. It accepts 3-beat car packets (id, x, y) over a valid/ready handshake and keeps an internal per-ID table of last position. For each packet it emits one result record: new location, speed from the forward y-delta using a zone-dependent gain with saturation, and a debounced "focus ID" with a change pulse.

## Interface
- WIDTH, 8: coordinate, id-beat and speed width.
- ID_W, 6: ID bits used; table has 2**ID_W entries.
- TH0, 150 / TH1, 200 / TH2, 250: y zone thresholds (WIDTH bits, TH0<TH1<TH2).
- G0, 92 / G1, 38 / G2, 26 / G3, 18: zone gains, unsigned 8-bit, units of 1/8.
- HOLD, 4: consecutive matching packets needed to move the focus ID (≥1).
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_sop  in  1  beat is an id beat (start of packet).
- in_data  in  WIDTH  beat payload: id (low ID_W bits), then x, then y.
- in_ready  out  1  block accepts a beat this cycle.
- out_valid  out  1  result record valid.
- out_ready  in  1  downstream accepts the record.
- out_id  out  ID_W  packet ID.
- out_x, out_y  out  WIDTH  packet coordinates (location write data).
- out_speed  out  WIDTH  saturated speed; 0 when out_speed_ok=0.
- out_speed_ok  out  1  speed is meaningful (speed memory write enable).
- focus_id  out  ID_W  debounced focus ID.
- focus_change  out  1  one-cycle pulse when focus_id updates.

## Operation
- FSM states: S_ID, S_X, S_Y, S_CALC, S_OUT. Reset state is S_ID.
- in_ready=1 in S_ID, S_X and S_Y only. A beat is accepted when in_valid & in_ready.
- S_ID: an accepted beat with in_sop=1 latches the id and moves to S_X. A beat with in_sop=0 is dropped and the FSM stays in S_ID.
- S_X: an accepted beat latches x and moves to S_Y. S_Y: an accepted beat latches y and moves to S_CALC.
- Resync: an accepted beat with in_sop=1 in S_X or S_Y discards the partial packet, latches the beat as a new id and goes to S_X.
- Table: one entry per ID holding {valid, x, y}. The read is synchronous, addressed by the latched id. All valid bits clear on reset.
- S_CALC: always moves to S_OUT. It registers the outputs and writes {1, x, y} to table[id].
- Speed rule, using prev = table[id]:
  - If the entry is invalid, or the new x=0 and y=0, or y ≤ prev.y: out_speed_ok=0 and out_speed=0.
  - Otherwise dy = y − prev.y (WIDTH bits). Gain = G0 if y<TH0, G1 if y<TH1, G2 if y<TH2, else G3.
  - p = dy*gain (WIDTH+8 bits); s = p>>3. out_speed = min(s, 2**WIDTH−1).
- S_OUT: out_valid=1 and outputs are held stable until out_ready=1. It then returns to S_ID, with in_ready=1 on the next cycle.
- Focus debounce, evaluated in S_CALC on every packet (including new cars):
  - If id==focus_id: cnt←0.
  - Else if id==cand: cnt←cnt+1. Else: cand←id, cnt←1.
  - When the updated count equals HOLD: focus_id←id, cnt←0, and focus_change=1 in the cycle the record enters S_OUT.

## Timing
- Reset values:
  - out_valid, out_speed, out_speed_ok, out_id, out_x, out_y = 0.
  - focus_id=0, focus_change=0, cand=0, cnt=0.
  - in_ready=1 (in S_ID); all table valid bits cleared.
- Latency: y beat accepted at edge t → out_valid=1 from cycle t+2.
- Minimum period is 5 cycles per packet with out_ready held high.
- focus_change is high exactly one cycle, coincident with the first out_valid cycle of its record.
- A back-to-back packet with the same ID reads the value written by the previous packet; the write completes before the next S_Y.
- Reset asserted mid-packet or mid-S_OUT: the FSM returns to S_ID immediately, out_valid drops asynchronously, and the table is invalidated.

## Test plan
- New car: packet (5, 10, 100) after reset → out_id=5, out_x=10, out_y=100, out_speed_ok=0, out_speed=0; out_valid 2 cycles after the y beat.
- Zone 0: then (5, 10, 110) → dy=10, 10*92>>3 → out_speed=115, ok=1. Zone 1: entry y=160, packet y=180 → 20*38>>3 = 95.
- Saturation: entry y=80, packet y=120 → 40*92>>3 = 460 → out_speed=255. Reverse motion: y=70 → ok=0, and the entry updates to y=70.
- Backpressure: hold out_ready=0 for 6 cycles → record stable, in_ready=0 throughout; out_ready=1 → in_ready=1 on the next cycle.
- Resync: id 3, x 20, then an in_sop beat with id 7, then x 30, y 40 → one record only, out_id=7, out_x=30, out_y=40.
- Focus, HOLD=4: IDs 9,9,9 → no change; 2 (resets cand); then 9,9,9,9 → focus_change pulse on the 4th, focus_id=9. Also assert rst_n low during S_Y → all outputs 0 and the next packet for that ID is treated as a new car.

Source files
------------

// File: rtl/speed_tracker.sv
// speed_tracker: parses 3-beat (id, x, y) car packets, keeps a per-ID table of the
// last y position and emits one result record per packet (location, zone-gain speed
// with saturation, debounced focus ID with a one-cycle change pulse).
// Ports: in_valid/in_sop/in_data/in_ready (beat input), out_* record with
// out_valid/out_ready handshake, focus_id/focus_change; clk, async active-low rst_n.
// Latency: y beat accepted at edge t -> out_valid from cycle t+2; 5 cycles/packet min.
// Backpressure: in_ready drops while a packet is computed or its record is held;
// the record stays stable in S_OUT until out_ready=1.
module speed_tracker #(
    parameter int              WIDTH = 8,
    parameter int              ID_W  = 6,
    parameter logic [WIDTH-1:0] TH0  = 150,
    parameter logic [WIDTH-1:0] TH1  = 200,
    parameter logic [WIDTH-1:0] TH2  = 250,
    parameter logic [7:0]      G0    = 8'd92,
    parameter logic [7:0]      G1    = 8'd38,
    parameter logic [7:0]      G2    = 8'd26,
    parameter logic [7:0]      G3    = 8'd18,
    parameter int              HOLD  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ID_W-1:0]  out_id,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_speed,
    output logic             out_speed_ok,
    output logic [ID_W-1:0]  focus_id,
    output logic             focus_change
);

    localparam int DEPTH = 2 ** ID_W;
    localparam int CW    = $clog2(HOLD + 1);
    localparam logic [CW-1:0] HOLD_C = CW'(HOLD);

    typedef enum logic [2:0] {S_ID, S_X, S_Y, S_CALC, S_OUT} state_t;

    state_t             state;
    logic [ID_W-1:0]    id_r;
    logic [WIDTH-1:0]   x_r;
    logic [WIDTH-1:0]   y_r;

    // Only the y history feeds the speed calculation; x positions go straight out
    // to the external location memory, so the table keeps {valid, y}.
    logic [DEPTH-1:0]   tbl_vld;
    logic [WIDTH-1:0]   tbl_y [DEPTH];
    logic               prev_vld;
    logic [WIDTH-1:0]   prev_y;

    logic [ID_W-1:0]    cand;
    logic [CW-1:0]      cnt;

    assign in_ready = (state == S_ID) || (state == S_X) || (state == S_Y);

    // Synchronous table read, addressed by the latched id. It is re-read every
    // cycle, so by S_CALC prev_* reflects the entry as of the y-beat edge, which
    // already includes the write made by any previous packet's S_CALC.
    always_ff @(posedge clk) begin
        prev_y <= tbl_y[id_r];
        if (state == S_CALC) begin
            tbl_y[id_r] <= y_r;
        end
    end

    // Speed datapath, evaluated in S_CALC.
    logic [WIDTH-1:0]   dy;
    logic [7:0]         gain;
    logic [WIDTH+7:0]   prod;
    logic [WIDTH+4:0]   scaled;
    logic               speed_ok;
    logic [WIDTH-1:0]   speed;

    always_comb begin
        dy = y_r - prev_y;
        if (y_r < TH0) begin
            gain = G0;
        end else if (y_r < TH1) begin
            gain = G1;
        end else if (y_r < TH2) begin
            gain = G2;
        end else begin
            gain = G3;
        end
        prod     = {8'd0, dy} * {{WIDTH{1'b0}}, gain};
        scaled   = prod[WIDTH+7:3];
        // (0,0) is the detector's "no position" marker, never a real movement.
        speed_ok = prev_vld && !((x_r == '0) && (y_r == '0)) && (y_r > prev_y);
        if (!speed_ok) begin
            speed = '0;
        end else if (|scaled[WIDTH+4:WIDTH]) begin
            speed = '1;
        end else begin
            speed = scaled[WIDTH-1:0];
        end
    end

    // Focus debounce: count consecutive packets for a candidate ID.
    logic [CW-1:0] cnt_upd;

    always_comb begin
        cnt_upd = (id_r == cand) ? (cnt + CW'(1)) : CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_ID;
            id_r         <= '0;
            x_r          <= '0;
            y_r          <= '0;
            tbl_vld      <= '0;
            prev_vld     <= 1'b0;
            out_valid    <= 1'b0;
            out_id       <= '0;
            out_x        <= '0;
            out_y        <= '0;
            out_speed    <= '0;
            out_speed_ok <= 1'b0;
            focus_id     <= '0;
            focus_change <= 1'b0;
            cand         <= '0;
            cnt          <= '0;
        end else begin
            prev_vld     <= tbl_vld[id_r];
            focus_change <= 1'b0;
            case (state)
                S_ID: begin
                    // Non-sop beats here are stray payload and are dropped.
                    if (in_valid && in_sop) begin
                        id_r  <= in_data[ID_W-1:0];
                        state <= S_X;
                    end
                end
                S_X: begin
                    if (in_valid) begin
                        if (in_sop) begin
                            id_r <= in_data[ID_W-1:0];
                        end else begin
                            x_r   <= in_data;
                            state <= S_Y;
                        end
                    end
                end
                S_Y: begin
                    if (in_valid) begin
                        if (in_sop) begin
                            id_r  <= in_data[ID_W-1:0];
                            state <= S_X;
                        end else begin
                            y_r   <= in_data;
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    out_valid     <= 1'b1;
                    out_id        <= id_r;
                    out_x         <= x_r;
                    out_y         <= y_r;
                    out_speed     <= speed;
                    out_speed_ok  <= speed_ok;
                    tbl_vld[id_r] <= 1'b1;
                    if (id_r == focus_id) begin
                        cnt <= '0;
                    end else begin
                        if (id_r != cand) begin
                            cand <= id_r;
                        end
                        if (cnt_upd == HOLD_C) begin
                            focus_id     <= id_r;
                            focus_change <= 1'b1;
                            cnt          <= '0;
                        end else begin
                            cnt <= cnt_upd;
                        end
                    end
                    state <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_ID;
                    end
                end
                default: state <= S_ID;
            endcase
        end
    end

endmodule

// File: tb/tb_speed_tracker.sv
module tb_speed_tracker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_sop, in_ready;
    logic [7:0] in_data;
    logic       out_valid, out_ready;
    logic [5:0] out_id, focus_id;
    logic [7:0] out_x, out_y, out_speed;
    logic       out_speed_ok, focus_change;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    speed_tracker dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_sop(in_sop), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_x(out_x), .out_y(out_y),
        .out_speed(out_speed), .out_speed_ok(out_speed_ok),
        .focus_id(focus_id), .focus_change(focus_change)
    );

    typedef struct {
        logic [5:0] id;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] speed;
        logic       ok;
        logic [5:0] fid;
        logic       fchg;
    } rec_t;

    rec_t sbq[$];

    // Reference model state
    bit         m_vld [64];
    logic [7:0] m_y   [64];
    logic [5:0] m_focus, m_cand;
    int         m_cnt;

    // Last record observed on the output, for literal checks in the tests
    logic [5:0] last_id;
    logic [7:0] last_x, last_y, last_speed;
    logic       last_ok, last_fchg;

    task model_reset();
        for (int i = 0; i < 64; i++) begin
            m_vld[i] = 0;
            m_y[i]   = '0;
        end
        m_focus = '0;
        m_cand  = '0;
        m_cnt   = 0;
    endtask

    task model_push(input logic [5:0] id, input logic [7:0] x, input logic [7:0] y);
        rec_t r;
        int dy, g, s;
        r.id = id;
        r.x  = x;
        r.y  = y;
        if (!m_vld[id] || (x == 0 && y == 0) || y <= m_y[id]) begin
            r.ok    = 1'b0;
            r.speed = 8'd0;
        end else begin
            dy = int'(y) - int'(m_y[id]);
            g  = (y < 150) ? 92 : (y < 200) ? 38 : (y < 250) ? 26 : 18;
            s  = (dy * g) / 8;
            if (s > 255) s = 255;
            r.ok    = 1'b1;
            r.speed = s[7:0];
        end
        m_vld[id] = 1;
        m_y[id]   = y;
        r.fchg = 1'b0;
        if (id == m_focus) begin
            m_cnt = 0;
        end else begin
            if (id == m_cand) begin
                m_cnt++;
            end else begin
                m_cand = id;
                m_cnt  = 1;
            end
            if (m_cnt == 4) begin
                m_focus = id;
                m_cnt   = 0;
                r.fchg  = 1'b1;
            end
        end
        r.fid = m_focus;
        sbq.push_back(r);
    endtask

    task send_beat(input logic sop, input logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_sop   = sop;
        in_data  = d;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL beat_accept: in_ready=%b required 1 within 50 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task send_pkt(input logic [5:0] id, input logic [7:0] x, input logic [7:0] y);
        model_push(id, x, y);
        send_beat(1'b1, {2'b00, id});
        send_beat(1'b0, x);
        send_beat(1'b0, y);
    endtask

    // Called just after the y beat's accept edge; pops and checks one record.
    task collect(input int stall);
        rec_t e;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL calc_cycle: out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: out_valid=%b required 1 two cycles after y beat", out_valid);
        end
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: record seen with empty queue, got 0 expected 1 entries");
        end else begin
            e = sbq.pop_front();
            checks++;
            if ({out_id, out_x, out_y, out_speed, out_speed_ok, focus_id} !==
                {e.id, e.x, e.y, e.speed, e.ok, e.fid}) begin
                errors++;
                $display("FAIL record: got id=%0d x=%0d y=%0d spd=%0d ok=%b fid=%0d expected id=%0d x=%0d y=%0d spd=%0d ok=%b fid=%0d",
                         out_id, out_x, out_y, out_speed, out_speed_ok, focus_id,
                         e.id, e.x, e.y, e.speed, e.ok, e.fid);
            end
            checks++;
            if (focus_change !== e.fchg) begin
                errors++;
                $display("FAIL focus_change: got %b expected %b (id=%0d)", focus_change, e.fchg, e.id);
            end
            last_id    = out_id;
            last_x     = out_x;
            last_y     = out_y;
            last_speed = out_speed;
            last_ok    = out_speed_ok;
            last_fchg  = focus_change;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || focus_change !== 1'b0 ||
                    {out_id, out_x, out_y, out_speed, out_speed_ok} !== {e.id, e.x, e.y, e.speed, e.ok}) begin
                    errors++;
                    $display("FAIL stall_hold: cycle %0d vld=%b rdy=%b fchg=%b id=%0d x=%0d y=%0d spd=%0d expected 1 0 0 %0d %0d %0d %0d",
                             i, out_valid, in_ready, focus_change, out_id, out_x, out_y, out_speed,
                             e.id, e.x, e.y, e.speed);
                end
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || focus_change !== 1'b0) begin
            errors++;
            $display("FAIL release: out_valid=%b in_ready=%b focus_change=%b required 0 1 0",
                     out_valid, in_ready, focus_change);
        end
    endtask

    task test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_id, out_x, out_y, out_speed, out_speed_ok, focus_id, focus_change, in_ready} !==
            {1'b0, 6'd0, 8'd0, 8'd0, 8'd0, 1'b0, 6'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: vld=%b id=%0d x=%0d y=%0d spd=%0d ok=%b fid=%0d fchg=%b rdy=%b required all 0, rdy=1",
                     out_valid, out_id, out_x, out_y, out_speed, out_speed_ok, focus_id, focus_change, in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task test_speed_zones();
        send_pkt(6'd5, 8'd10, 8'd100); collect(0);
        checks++;
        if (last_ok !== 1'b0 || last_speed !== 8'd0) begin
            errors++;
            $display("FAIL new_car: ok=%b spd=%0d required 0 0", last_ok, last_speed);
        end
        send_pkt(6'd5, 8'd10, 8'd110); collect(0);
        checks++;
        if (last_ok !== 1'b1 || last_speed !== 8'd115) begin
            errors++;
            $display("FAIL zone0: ok=%b spd=%0d required 1 115", last_ok, last_speed);
        end
        send_pkt(6'd6, 8'd1, 8'd160); collect(0);
        send_pkt(6'd6, 8'd1, 8'd180); collect(0);
        checks++;
        if (last_speed !== 8'd95) begin
            errors++;
            $display("FAIL zone1: spd=%0d required 95", last_speed);
        end
        send_pkt(6'd12, 8'd0, 8'd140); collect(0);
        send_pkt(6'd12, 8'd0, 8'd150); collect(0);
        checks++;
        if (last_speed !== 8'd47) begin
            errors++;
            $display("FAIL th0_edge: spd=%0d required 47", last_speed);
        end
        send_pkt(6'd10, 8'd0, 8'd200); collect(0);
        send_pkt(6'd10, 8'd0, 8'd210); collect(0);
        checks++;
        if (last_speed !== 8'd32) begin
            errors++;
            $display("FAIL zone2: spd=%0d required 32", last_speed);
        end
        send_pkt(6'd10, 8'd0, 8'd255); collect(0);
        checks++;
        if (last_speed !== 8'd101) begin
            errors++;
            $display("FAIL zone3: spd=%0d required 101", last_speed);
        end
    endtask

    task test_saturation();
        send_pkt(6'd8, 8'd1, 8'd80);  collect(0);
        send_pkt(6'd8, 8'd1, 8'd120); collect(0);
        checks++;
        if (last_ok !== 1'b1 || last_speed !== 8'd255) begin
            errors++;
            $display("FAIL saturate: ok=%b spd=%0d required 1 255", last_ok, last_speed);
        end
        send_pkt(6'd8, 8'd1, 8'd70); collect(0);
        checks++;
        if (last_ok !== 1'b0 || last_speed !== 8'd0) begin
            errors++;
            $display("FAIL reverse: ok=%b spd=%0d required 0 0", last_ok, last_speed);
        end
        send_pkt(6'd8, 8'd1, 8'd75); collect(0);
        checks++;
        if (last_speed !== 8'd57) begin
            errors++;
            $display("FAIL reverse_update: spd=%0d required 57", last_speed);
        end
    endtask

    task test_backpressure();
        send_pkt(6'd20, 8'd3, 8'd50);
        collect(6);
    endtask

    task test_resync();
        model_push(6'd7, 8'd30, 8'd40);
        send_beat(1'b0, 8'd55);
        send_beat(1'b1, 8'd3);
        send_beat(1'b0, 8'd20);
        send_beat(1'b1, 8'd7);
        send_beat(1'b0, 8'd30);
        send_beat(1'b0, 8'd40);
        collect(0);
        checks++;
        if (last_id !== 6'd7 || last_x !== 8'd30 || last_y !== 8'd40 || sbq.size() != 0) begin
            errors++;
            $display("FAIL resync: id=%0d x=%0d y=%0d pending=%0d required 7 30 40 0",
                     last_id, last_x, last_y, sbq.size());
        end
    endtask

    task test_focus();
        for (int i = 0; i < 3; i++) begin
            send_pkt(6'd9, 8'd2, 8'(10 + i * 10)); collect(0);
        end
        checks++;
        if (focus_id === 6'd9) begin
            errors++;
            $display("FAIL focus_early: focus_id=%0d required not 9", focus_id);
        end
        send_pkt(6'd2, 8'd2, 8'd5); collect(0);
        for (int i = 0; i < 4; i++) begin
            send_pkt(6'd9, 8'd2, 8'(40 + i * 10)); collect(0);
            checks++;
            if (last_fchg !== (i == 3)) begin
                errors++;
                $display("FAIL focus_pulse: packet %0d fchg=%b required %b", i, last_fchg, (i == 3));
            end
        end
        checks++;
        if (focus_id !== 6'd9) begin
            errors++;
            $display("FAIL focus_id: got %0d required 9", focus_id);
        end
    endtask

    task test_reset_mid();
        send_beat(1'b1, 8'd9);
        send_beat(1'b0, 8'd4);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_speed, out_speed_ok, focus_id, focus_change, in_ready} !==
            {1'b0, 8'd0, 1'b0, 6'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_in_y: vld=%b spd=%0d ok=%b fid=%0d fchg=%b rdy=%b required 0 0 0 0 0 1",
                     out_valid, out_speed, out_speed_ok, focus_id, focus_change, in_ready);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send_pkt(6'd9, 8'd4, 8'd100); collect(0);
        checks++;
        if (last_ok !== 1'b0) begin
            errors++;
            $display("FAIL new_after_reset: ok=%b required 0", last_ok);
        end
        // Reset while a record is waiting in S_OUT
        send_pkt(6'd9, 8'd4, 8'd110);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_hold_pre_reset: out_valid=%b required 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_out: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        void'(sbq.pop_front());
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send_pkt(6'd9, 8'd4, 8'd120); collect(0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_speed_zones();
        test_saturation();
        test_backpressure();
        test_resync();
        test_focus();
        test_reset_mid();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d records pending, required 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
